mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single runtime memory port between the core load/store path and the JTAG debug port.
- The debug port issues one-cycle request pulses on the system clock. The arbiter captures each pulse, holds it until the port is free, and schedules it fairly against core requests.
- The arbiter tracks read latency and returns read data to whichever requester issued the read.
- It sits between the core/debug blocks and the memory macro, in the system clock domain.

Parameters:
ADDR_W, 16, address width.
DATA_W, 16, data width.
RD_LAT, 1, memory read latency in cycles (legal 1..3).

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_coreReq  in  1  core request valid; held with its fields until o_coreGnt
i_coreWr  in  1  1=write, 0=read
i_coreAddr  in  ADDR_W  core address
i_coreData  in  DATA_W  core write data
o_coreGnt  out  1  combinational; high in the cycle the core request issues
o_coreRdData  out  DATA_W  registered core read data
o_coreRdValid  out  1  one-cycle pulse; o_coreRdData valid
i_jtagEn  in  1  one-cycle debug request pulse
i_jtagWr  in  1  sampled with i_jtagEn
i_jtagAddr  in  ADDR_W  sampled with i_jtagEn
i_jtagData  in  DATA_W  sampled with i_jtagEn
o_jtagRdData  out  DATA_W  last debug read result; held until the next debug read completes
o_jtagBusy  out  1  debug request pending or in flight
o_jtagOverrun  out  1  sticky; a debug pulse was dropped
o_memAddr  out  ADDR_W  memory address
o_memData  out  DATA_W  memory write data
o_memWr  out  1  memory write strobe qualifier
o_memEn  out  1  memory access strobe; exactly one cycle per access
i_memRdData  in  DATA_W  memory read data, valid RD_LAT cycles after a read issue

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge):
  - FSM goes to IDLE.
  - JTAG pending, overrun, both read-data registers and o_coreRdValid are cleared to 0.
  - lastGnt is set to JTAG.
  - Any in-flight read is discarded; no rdValid pulse is produced for it.
  - o_mem* are 0 while in reset.
- JTAG capture:
  - On i_jtagEn with no debug request pending or in flight, latch wr/addr/data and set pending.
  - The request is issuable from the next cycle onward.
  - i_jtagEn while o_jtagBusy=1: the pulse is dropped and o_jtagOverrun is set. Only reset clears o_jtagOverrun.
- o_jtagBusy = pending | (in-flight read owned by JTAG).
- FSM has two states, IDLE and RDWAIT.
- IDLE:
  - Candidates are i_coreReq and JTAG pending.
  - Exactly one candidate: issue it.
  - Both candidates: issue the one that is not lastGnt, then update lastGnt. After reset the core wins the first tie.
  - Issue cycle:
    - o_memEn=1.
    - o_memAddr/o_memData/o_memWr are muxed from the winner.
    - o_coreGnt=1 if the core won; if JTAG won, pending clears at the edge.
  - A write completes in its issue cycle; the FSM stays in IDLE, so back-to-back writes run every cycle.
  - A read loads the latency counter with RD_LAT, records the owner, and moves to RDWAIT.
- RDWAIT:
  - No issue; o_memEn=0, o_coreGnt=0.
  - The counter decrements each cycle.
  - In the cycle the counter is 1, i_memRdData is captured into the owner's read register and the FSM returns to IDLE.
  - Read issued at cycle t: capture at the edge ending cycle t+RD_LAT.
  - Core owner: o_coreRdValid=1 in cycle t+RD_LAT+1.
  - JTAG owner: o_jtagRdData is updated for cycle t+RD_LAT+1 and o_jtagBusy falls in that cycle.
  - The next issue is possible in cycle t+RD_LAT+1.
- Simultaneous events:
  - i_jtagEn in a cycle where nothing is pending is captured even if the core is issuing that cycle.
  - The captured request does not compete until the following cycle.
- When not issuing, o_mem* outputs are 0.
- No combinational path from i_jtag* to o_mem*.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, RDWAIT)
  - the owner enum (OWN_CORE, OWN_JTAG)
  - ADDR_W/DATA_W defaults
  - the latency-counter width (2 bits)
- One sub-module, mem_arb_rd_tracker:
  - contains the latency counter and owner tag
  - outputs busy and a capture strobe tagged with the owner

Test Plan:
- Core write, addr 0x0010, data 0xBEEF, then a second write to 0x0011: o_coreGnt and o_memEn=1 with o_memWr=1 in consecutive cycles t and t+1.
- Core read of 0x0020, RD_LAT=1, memory returns 0x1234 at t+1: o_coreRdValid=1 with data 0x1234 at t+2; a core request held meanwhile is granted no earlier than t+2.
- JTAG pulse read of 0x0100, memory returns 0xA5A5:
  - o_jtagBusy=1 from the cycle after the pulse until the capture.
  - o_jtagRdData=0xA5A5 and holds.
  - Core requests are blocked during RDWAIT.
- Core request held continuously while JTAG writes are pulsed, starting right after reset: grant order core, JTAG, core, JTAG, with no starvation.
- Second i_jtagEn while busy: only the first access appears on o_mem*, o_jtagOverrun=1 and stays set until i_rst.
- RD_LAT=3 read issued, i_rst asserted at t+1: no rdValid pulse, all outputs 0, the next request issues normally from IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the runtime memory port arbiter.
// Read latency is bounded to 1..3 cycles, so a 2-bit counter suffices.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned CNT_W      = 2;

   typedef enum logic {IDLE, RDWAIT} state_e;
   typedef enum logic {OWN_CORE, OWN_JTAG} owner_e;

endpackage

// File: rtl/mem_arb_rd_tracker.sv
// Counts down the memory read latency of the single outstanding read and tags its owner.
// cap marks the last latency cycle, when read data is on i_memRdData.
module mem_arb_rd_tracker
   import mem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   input  owner_e start_owner,
   output logic   busy,
   output logic   cap,
   output owner_e owner
);

   logic [CNT_W-1:0] cnt_q;
   owner_e           owner_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         owner_q <= OWN_CORE;
      end else if (start) begin
         cnt_q   <= CNT_W'(RD_LAT);
         owner_q <= start_owner;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign busy  = (cnt_q != '0);
   assign cap   = (cnt_q == CNT_W'(1));
   assign owner = owner_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the runtime memory port between the core load/store path and captured
// JTAG debug pulses, alternating on contention and routing read data back to its owner.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_coreReq,
   input  logic              i_coreWr,
   input  logic [ADDR_W-1:0] i_coreAddr,
   input  logic [DATA_W-1:0] i_coreData,
   output logic              o_coreGnt,
   output logic [DATA_W-1:0] o_coreRdData,
   output logic              o_coreRdValid,
   input  logic              i_jtagEn,
   input  logic              i_jtagWr,
   input  logic [ADDR_W-1:0] i_jtagAddr,
   input  logic [DATA_W-1:0] i_jtagData,
   output logic [DATA_W-1:0] o_jtagRdData,
   output logic              o_jtagBusy,
   output logic              o_jtagOverrun,
   output logic [ADDR_W-1:0] o_memAddr,
   output logic [DATA_W-1:0] o_memData,
   output logic              o_memWr,
   output logic              o_memEn,
   input  logic [DATA_W-1:0] i_memRdData
);

   state_e            state_q;
   owner_e            last_gnt_q;
   logic              jtag_pend_q, jtag_wr_q, overrun_q, core_rd_valid_q;
   logic [ADDR_W-1:0] jtag_addr_q;
   logic [DATA_W-1:0] jtag_data_q, core_rd_q, jtag_rd_q;

   logic   trk_busy, trk_cap;
   owner_e trk_owner;
   logic   can_issue, core_cand, jtag_cand, pick_jtag, issue, issue_rd;

   // JTAG only ever competes from its captured registers, so i_jtag* never reach o_mem*.
   always_comb begin
      can_issue = !i_rst && (state_q == IDLE);
      core_cand = can_issue && i_coreReq;
      jtag_cand = can_issue && jtag_pend_q;
      pick_jtag = jtag_cand && (!core_cand || (last_gnt_q == OWN_CORE));
      issue     = core_cand || jtag_cand;
      o_coreGnt = core_cand && !pick_jtag;
      o_memEn   = issue;
      o_memWr   = 1'b0;
      o_memAddr = '0;
      o_memData = '0;
      if (pick_jtag) begin
         o_memWr   = jtag_wr_q;
         o_memAddr = jtag_addr_q;
         o_memData = jtag_data_q;
      end else if (core_cand) begin
         o_memWr   = i_coreWr;
         o_memAddr = i_coreAddr;
         o_memData = i_coreData;
      end
      issue_rd = issue && !o_memWr;
   end

   assign o_jtagBusy    = jtag_pend_q | (trk_busy && (trk_owner == OWN_JTAG));
   assign o_jtagOverrun = overrun_q;
   assign o_jtagRdData  = jtag_rd_q;
   assign o_coreRdData  = core_rd_q;
   assign o_coreRdValid = core_rd_valid_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q         <= IDLE;
         last_gnt_q      <= OWN_JTAG;
         jtag_pend_q     <= 1'b0;
         overrun_q       <= 1'b0;
         core_rd_q       <= '0;
         jtag_rd_q       <= '0;
         core_rd_valid_q <= 1'b0;
      end else begin
         core_rd_valid_q <= trk_cap && (trk_owner == OWN_CORE);
         unique case (state_q)
            IDLE: begin
               if (issue) begin
                  last_gnt_q <= pick_jtag ? OWN_JTAG : OWN_CORE;
                  if (issue_rd) state_q <= RDWAIT;
               end
            end
            RDWAIT: begin
               if (trk_cap) begin
                  if (trk_owner == OWN_CORE) core_rd_q <= i_memRdData;
                  else                       jtag_rd_q <= i_memRdData;
                  state_q <= IDLE;
               end
            end
         endcase
         if (pick_jtag) jtag_pend_q <= 1'b0;
         if (i_jtagEn) begin
            if (o_jtagBusy) overrun_q   <= 1'b1;
            else            jtag_pend_q <= 1'b1;
         end
      end
   end

   // Request fields are only consumed while pending, so they need no reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst && i_jtagEn && !o_jtagBusy) begin
         jtag_wr_q   <= i_jtagWr;
         jtag_addr_q <= i_jtagAddr;
         jtag_data_q <= i_jtagData;
      end
   end

   mem_arb_rd_tracker #(
      .RD_LAT (RD_LAT)
   ) u_rd_tracker (
      .clk         (i_clk),
      .rst         (i_rst),
      .start       (issue_rd),
      .start_owner (pick_jtag ? OWN_JTAG : OWN_CORE),
      .busy        (trk_busy),
      .cap         (trk_cap),
      .owner       (trk_owner)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter plus a directed reset-during-read case
// on a second instance built with the longest read latency.
module tb_mem_arbiter;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, core_req, core_wr, jtag_en, jtag_wr;
   logic [15:0] core_addr, core_data, jtag_addr, jtag_data, mem_rd;
   logic        o_core_gnt, o_core_rd_valid, o_jtag_busy, o_jtag_ovr, o_mem_wr, o_mem_en;
   logic [15:0] o_core_rd, o_jtag_rd, o_mem_addr, o_mem_data;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_coreReq(core_req), .i_coreWr(core_wr), .i_coreAddr(core_addr), .i_coreData(core_data),
      .o_coreGnt(o_core_gnt), .o_coreRdData(o_core_rd), .o_coreRdValid(o_core_rd_valid),
      .i_jtagEn(jtag_en), .i_jtagWr(jtag_wr), .i_jtagAddr(jtag_addr), .i_jtagData(jtag_data),
      .o_jtagRdData(o_jtag_rd), .o_jtagBusy(o_jtag_busy), .o_jtagOverrun(o_jtag_ovr),
      .o_memAddr(o_mem_addr), .o_memData(o_mem_data), .o_memWr(o_mem_wr), .o_memEn(o_mem_en),
      .i_memRdData(mem_rd)
   );

   logic        d3_rst, d3_req, d3_wr, d3_gnt, d3_rd_valid, d3_busy, d3_ovr, d3_mem_wr, d3_mem_en;
   logic [15:0] d3_addr, d3_data, d3_core_rd, d3_jtag_rd, d3_mem_addr, d3_mem_data;
   logic        d3_zero1 = 1'b0;
   logic [15:0] d3_zero16 = 16'h0000;
   logic [15:0] d3_mem_rd = 16'h5A5A;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) u_dut3 (
      .i_clk(clk), .i_rst(d3_rst),
      .i_coreReq(d3_req), .i_coreWr(d3_wr), .i_coreAddr(d3_addr), .i_coreData(d3_data),
      .o_coreGnt(d3_gnt), .o_coreRdData(d3_core_rd), .o_coreRdValid(d3_rd_valid),
      .i_jtagEn(d3_zero1), .i_jtagWr(d3_zero1), .i_jtagAddr(d3_zero16), .i_jtagData(d3_zero16),
      .o_jtagRdData(d3_jtag_rd), .o_jtagBusy(d3_busy), .o_jtagOverrun(d3_ovr),
      .o_memAddr(d3_mem_addr), .o_memData(d3_mem_data), .o_memWr(d3_mem_wr), .o_memEn(d3_mem_en),
      .i_memRdData(d3_mem_rd)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {int cyc; logic [63:0] port; logic [63:0] jtag;} cyc_exp_t;
   typedef struct {int cyc; logic [15:0] data;} rd_exp_t;
   cyc_exp_t    exp_q[$];
   rd_exp_t     core_rd_exp[$];
   logic [32:0] core_txq[$];

   logic [15:0] mem   [0:65535];
   logic [15:0] s_mem [0:65535];
   logic        gnt_seen = 1'b0;

   // Reference model: per cycle, decides which request the port should carry and when
   // read results are due, from pending flags, a last-winner bit and due-cycle numbers.
   initial begin : model
      int          cyc, free_at, jrd_at;
      logic        pend, jwr, ovr, last_j, own_j, inflight, jbusy, en, wr, gnt, pj;
      logic [15:0] jaddr, jdata, jrd, jrd_val, a, d;
      cyc_exp_t    e;
      rd_exp_t     r;
      cyc = 0; free_at = 0; jrd_at = -1;
      pend = 0; jwr = 0; ovr = 0; last_j = 1; own_j = 0;
      jaddr = 0; jdata = 0; jrd = 0; jrd_val = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc == jrd_at) jrd = jrd_val;
         inflight = cyc < free_at;
         jbusy = pend || (inflight && own_j);
         en = 0; wr = 0; gnt = 0; pj = 0; a = 0; d = 0;
         if (!rst && !inflight && (core_req || pend)) begin
            en = 1;
            pj = pend && (!core_req || !last_j);
            if (pj) begin
               wr = jwr; a = jaddr; d = jdata;
            end else begin
               wr = core_wr; a = core_addr; d = core_data; gnt = 1;
            end
         end
         e.cyc = cyc;
         e.port = 64'({en, wr, gnt, a, d});
         e.jtag = 64'({jbusy, ovr, jrd});
         exp_q.push_back(e);
         gnt_seen = o_core_gnt;
         if (rst) begin
            pend = 0; ovr = 0; jrd = 0; last_j = 1; free_at = cyc + 1; jrd_at = -1;
            while (core_rd_exp.size() > 0 && core_rd_exp[$].cyc > cyc) void'(core_rd_exp.pop_back());
         end else begin
            if (en) begin
               last_j = pj;
               if (pj) pend = 0;
               if (wr) s_mem[a] = d;
               else begin
                  free_at = cyc + LAT + 1;
                  own_j = pj;
                  if (pj) begin
                     jrd_at = cyc + LAT + 1;
                     jrd_val = s_mem[a];
                  end else begin
                     r.cyc = cyc + LAT + 1;
                     r.data = s_mem[a];
                     core_rd_exp.push_back(r);
                  end
               end
            end
            if (jtag_en) begin
               if (jbusy) ovr = 1;
               else begin
                  pend = 1; jwr = jtag_wr; jaddr = jtag_addr; jdata = jtag_data;
               end
            end
         end
      end
   end

   // Monitor: compares the DUT against whatever the model queued for this cycle.
   initial begin : monitor
      cyc_exp_t e;
      rd_exp_t  r;
      logic     exp_v;
      forever begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) continue;
         e = exp_q.pop_front();
         chk("mem_port{en,wr,gnt,addr,data}",
             64'({o_mem_en, o_mem_wr, o_core_gnt, o_mem_addr, o_mem_data}), e.port);
         chk("jtag{busy,overrun,rddata}", 64'({o_jtag_busy, o_jtag_ovr, o_jtag_rd}), e.jtag);
         exp_v = (core_rd_exp.size() > 0) && (core_rd_exp[0].cyc == e.cyc);
         chk("core_rd_valid", 64'(o_core_rd_valid), 64'(exp_v));
         if (exp_v) begin
            r = core_rd_exp.pop_front();
            if (o_core_rd_valid) chk("core_rd_data", 64'(o_core_rd), 64'(r.data));
         end
      end
   end

   // Memory macro: read data appears after the issue edge and holds until the next read.
   initial begin : memory
      logic        s_en, s_wr;
      logic [15:0] s_a, s_d;
      mem_rd = 16'h0000;
      forever begin
         @(negedge clk);
         s_en = o_mem_en; s_wr = o_mem_wr; s_a = o_mem_addr; s_d = o_mem_data;
         @(posedge clk);
         #1;
         if (s_en === 1'b1) begin
            if (s_wr) mem[s_a] = s_d;
            else      mem_rd = mem[s_a];
         end
      end
   end

   // Core driver: presents the head transaction until it is granted.
   initial begin : core_drv
      core_req = 0; core_wr = 0; core_addr = 0; core_data = 0;
      forever begin
         step();
         if (core_req && gnt_seen) void'(core_txq.pop_front());
         if (core_txq.size() > 0) begin
            core_req = 1;
            {core_wr, core_addr, core_data} = core_txq[0];
         end else begin
            core_req = 0;
         end
      end
   end

   task automatic jtag_pulse(input logic wr, input logic [15:0] a, input logic [15:0] d);
      jtag_en = 1; jtag_wr = wr; jtag_addr = a; jtag_data = d;
      step();
      jtag_en = 0;
   endtask

   task automatic core_push(input logic wr, input logic [15:0] a, input logic [15:0] d);
      core_txq.push_back({wr, a, d});
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && core_txq.size() > 0; i++) step();
      chk("core_queue_drained", 64'(core_txq.size()), 64'd0);
      repeat (6) step();
   endtask

   initial begin : timeout
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   initial begin : main
      logic [15:0] v;
      for (int i = 0; i < 65536; i++) begin
         v = 16'($urandom);
         mem[i] = v;
         s_mem[i] = v;
      end
      mem[16'h0020] = 16'h1234; s_mem[16'h0020] = 16'h1234;
      mem[16'h0100] = 16'hA5A5; s_mem[16'h0100] = 16'hA5A5;
      rst = 1; jtag_en = 0; jtag_wr = 0; jtag_addr = 0; jtag_data = 0;
      d3_rst = 1; d3_req = 0; d3_wr = 0; d3_addr = 0; d3_data = 0;
      repeat (3) step();
      rst = 0; d3_rst = 0;
      step();

      core_push(1, 16'h0010, 16'hBEEF);
      core_push(1, 16'h0011, 16'h1111);
      drain();
      core_push(0, 16'h0020, 16'h0000);
      core_push(1, 16'h0021, 16'h2222);
      drain();

      jtag_pulse(0, 16'h0100, 16'h0000);
      core_push(0, 16'h0010, 16'h0000);
      core_push(0, 16'h0011, 16'h0000);
      core_push(1, 16'h0012, 16'h3333);
      drain();

      rst = 1;
      step();
      rst = 0;
      for (int i = 0; i < 6; i++) core_push(1, 16'h0040 + 16'(i), 16'h4000 + 16'(i));
      for (int i = 0; i < 3; i++) begin
         jtag_pulse(1, 16'h0050 + 16'(i), 16'h5000 + 16'(i));
         step();
      end
      drain();

      jtag_pulse(0, 16'h0100, 16'h0000);
      jtag_pulse(1, 16'h0200, 16'hDEAD);
      repeat (8) step();

      for (int i = 0; i < 3000; i++) begin
         if (core_txq.size() < 2 && $urandom_range(0, 2) == 0)
            core_push(1'($urandom), 16'($urandom_range(0, 31)), 16'($urandom));
         jtag_en = ($urandom_range(0, 4) == 0);
         jtag_wr = 1'($urandom);
         jtag_addr = 16'($urandom_range(0, 31));
         jtag_data = 16'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      jtag_en = 0; rst = 0;
      drain();
      repeat (10) step();
      chk("core_rd_outstanding", 64'(core_rd_exp.size()), 64'd0);

      // Reset one cycle after a 3-cycle read issues: the read must vanish.
      d3_req = 1; d3_wr = 0; d3_addr = 16'h0030;
      @(negedge clk);
      chk("d3_read_issue{gnt,en,wr}", 64'({d3_gnt, d3_mem_en, d3_mem_wr}), 64'b110);
      step();
      d3_rst = 1; d3_req = 1; d3_wr = 1; d3_addr = 16'h0031; d3_data = 16'h7777;
      @(negedge clk);
      chk("d3_in_reset_mem_outputs",
          64'({d3_gnt, d3_mem_en, d3_mem_wr, d3_mem_addr, d3_mem_data}), 64'd0);
      step();
      d3_rst = 0;
      @(negedge clk);
      chk("d3_after_reset_state", 64'({d3_rd_valid, d3_core_rd, d3_jtag_rd, d3_busy, d3_ovr}),
          64'd0);
      chk("d3_issue_from_idle{gnt,en,wr,addr,data}",
          64'({d3_gnt, d3_mem_en, d3_mem_wr, d3_mem_addr, d3_mem_data}),
          64'({3'b111, 16'h0031, 16'h7777}));
      step();
      d3_req = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("d3_no_rd_valid", 64'({d3_rd_valid, d3_core_rd}), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
